// File: rtl/axi_master_arbiter_pkg.sv
// Shared types and widths for the cache-side AXI master arbiter.
// Line address and cache-line data widths default here unless a project header already defined them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH_CACHE
`define DATA_WIDTH_CACHE 128
`endif

package axi_master_arbiter_pkg;

    localparam int ADDR_WIDTH       = `ADDR_WIDTH;
    localparam int DATA_WIDTH_CACHE = `DATA_WIDTH_CACHE;

    // Requester 0 is the icache, requester 1 the dcache.
    localparam int N_REQ_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_WAIT_W = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_master_arbiter_if.sv
// CPU-side port of the AXI master: one line request out, read line / done pulses back.
interface axi_master_arbiter_if;
    import axi_master_arbiter_pkg::*;

    logic [ADDR_WIDTH-1:0]       addr;
    logic [DATA_WIDTH_CACHE-1:0] wdata;
    logic                        we;
    logic                        cs;
    logic [DATA_WIDTH_CACHE-1:0] rdata;
    logic                        rvalid;
    logic                        wdone;

    // master: the arbiter driving requests; slave: the AXI master serving them.
    modport master (
        output addr, wdata, we, cs,
        input  rdata, rvalid, wdone
    );

    modport slave (
        input  addr, wdata, we, cs,
        output rdata, rvalid, wdone
    );
endinterface

// File: rtl/axi_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request found searching upward from last_i+1, wrapping.
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] last_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] grant_idx_o
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        // last_i itself is visited last, so a sole requester is re-granted.
        for (int i = 1; i <= N_REQ; i++) begin
            cand     = (int'(last_i) + i) % N_REQ;
            cand_idx = PTR_W'(cand);
            if (!found && req_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI master between N_REQ cache requesters, one line transaction at a time.
module axi_master_arbiter
    import axi_master_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [N_REQ-1:0]                        req_cs_i,
    input  logic [N_REQ-1:0]                        req_we_i,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [N_REQ-1:0][DATA_WIDTH_CACHE-1:0]  req_wdata_i,
    output logic [DATA_WIDTH_CACHE-1:0]             req_rdata_o,
    output logic [N_REQ-1:0]                        req_rvalid_o,
    output logic [N_REQ-1:0]                        req_wdone_o,
    output logic [N_REQ-1:0]                        grant_o,
    axi_master_arbiter_if.master                    m_if
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_e                  state_q, state_d;
    logic [PTR_W-1:0]            last_q, last_d;
    logic [N_REQ-1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH_CACHE-1:0] wdata_q, wdata_d;
    logic                        we_q, we_d;

    logic [N_REQ-1:0]            arb_grant;
    logic [PTR_W-1:0]            arb_idx;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i       (req_cs_i),
        .last_i      (last_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= PTR_W'(N_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    // Requests are only looked at in IDLE, so only one transaction is ever in flight.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_cs_i) begin
                    grant_d = arb_grant;
                    last_d  = arb_idx;
                    addr_d  = req_addr_i[arb_idx];
                    wdata_d = req_wdata_i[arb_idx];
                    we_d    = req_we_i[arb_idx];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_WAIT_W : ST_WAIT_R;
            end
            ST_WAIT_R: begin
                if (m_if.rvalid) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_W: begin
                if (m_if.wdone) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_if.cs      = (state_q == ST_ISSUE);
    assign m_if.addr    = addr_q;
    assign m_if.wdata   = wdata_q;
    assign m_if.we      = we_q;
    assign req_rdata_o  = m_if.rdata;
    assign grant_o      = grant_q;

    // Done pulses reach only the owner, and only in the matching wait state.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_done
            assign req_rvalid_o[gi] = (state_q == ST_WAIT_R) && grant_q[gi] && m_if.rvalid;
            assign req_wdone_o[gi]  = (state_q == ST_WAIT_W) && grant_q[gi] && m_if.wdone;
        end
    endgenerate

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: reads, round-robin, writes, spurious pulses, mid-write reset.
module tb_axi_master_arbiter;
    import axi_master_arbiter_pkg::*;

    localparam int N = 2;

    logic                                clk = 1'b0;
    logic                                rst = 1'b1;
    logic [N-1:0]                        req_cs = '0;
    logic [N-1:0]                        req_we = '0;
    logic [N-1:0][ADDR_WIDTH-1:0]        req_addr = '0;
    logic [N-1:0][DATA_WIDTH_CACHE-1:0]  req_wdata = '0;
    logic [DATA_WIDTH_CACHE-1:0]         req_rdata;
    logic [N-1:0]                        req_rvalid;
    logic [N-1:0]                        req_wdone;
    logic [N-1:0]                        grant;

    int checks = 0;
    int errors = 0;

    axi_master_arbiter_if bus ();

    axi_master_arbiter #(.N_REQ(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_cs_i     (req_cs),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_rdata_o  (req_rdata),
        .req_rvalid_o (req_rvalid),
        .req_wdone_o  (req_wdone),
        .grant_o      (grant),
        .m_if         (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] RD_LINE = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
    localparam logic [127:0] WR_LINE = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_g;
        bus.rdata  = '0;
        bus.rvalid = 1'b0;
        bus.wdone  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_grant",  grant, 0);
        chk("rst_cs",     bus.cs, 0);
        chk("rst_we",     bus.we, 0);
        chk("rst_addr",   bus.addr, 0);
        chk("rst_wdata",  bus.wdata, 0);
        chk("rst_rvalid", req_rvalid, 0);
        chk("rst_wdone",  req_wdone, 0);
        rst = 1'b0;

        // Single read from requester 0
        req_cs = 2'b01; req_we = 2'b00; req_addr[0] = 32'h0000_0040;
        #1;
        chk("rd_cycle0_grant", grant, 0);
        step();
        chk("rd_issue_cs",    bus.cs, 1);
        chk("rd_issue_grant", grant, 2'b01);
        chk("rd_issue_addr",  bus.addr, 32'h40);
        chk("rd_issue_we",    bus.we, 0);
        step();
        chk("rd_wait_cs", bus.cs, 0);
        bus.rvalid = 1'b1; bus.rdata = RD_LINE;
        #1;
        chk("rd_rvalid", req_rvalid, 2'b01);
        chk("rd_rdata",  req_rdata, RD_LINE);
        step();
        bus.rvalid = 1'b0; req_cs = 2'b00;
        chk("rd_done_grant", grant, 0);
        chk("rd_done_cs",    bus.cs, 0);

        // Both requesters read continuously; last winner was 0
        req_cs = 2'b11; req_we = 2'b00; req_addr[1] = 32'h0000_0080;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            step();
            $display("rr txn %0d: grant=%b cs=%b", k, grant, bus.cs);
            chk("rr_grant", grant, exp_g);
            chk("rr_cs",    bus.cs, 1);
            step();
            chk("rr_wait_cs", bus.cs, 0);
            bus.rvalid = 1'b1;
            #1;
            chk("rr_rvalid", req_rvalid, exp_g);
            step();
            bus.rvalid = 1'b0;
            chk("rr_idle_grant", grant, 0);
            chk("rr_idle_cs",    bus.cs, 0);
        end
        req_cs = 2'b00;

        // Write from requester 1; requester 0 rises while busy
        req_cs = 2'b10; req_we = 2'b10; req_addr[1] = 32'h0002_0000; req_wdata[1] = WR_LINE;
        req_addr[0] = 32'h0000_0100; req_wdata[0] = '0;
        step();
        req_cs = 2'b11;
        chk("wr_grant", grant, 2'b10);
        chk("wr_cs",    bus.cs, 1);
        chk("wr_we",    bus.we, 1);
        chk("wr_addr",  bus.addr, 32'h0002_0000);
        chk("wr_wdata", bus.wdata, WR_LINE);
        step();
        chk("wr_wait_grant", grant, 2'b10);
        chk("wr_wait_addr",  bus.addr, 32'h0002_0000);
        bus.rvalid = 1'b1;
        #1;
        chk("wr_spurious_rvalid", req_rvalid, 0);
        step();
        bus.rvalid = 1'b0;
        chk("wr_still_grant", grant, 2'b10);
        chk("wr_still_wdata", bus.wdata, WR_LINE);
        bus.wdone = 1'b1;
        #1;
        chk("wr_wdone", req_wdone, 2'b10);
        step();
        bus.wdone = 1'b0; req_cs = 2'b01;
        chk("wr_idle_grant", grant, 0);
        chk("wr_idle_addr_hold", bus.addr, 32'h0002_0000);
        chk("wr_idle_we_hold",   bus.we, 1);

        // Pending requester 0 read; spurious wdone during WAIT_R
        step();
        chk("r0_grant", grant, 2'b01);
        chk("r0_addr",  bus.addr, 32'h0000_0100);
        step();
        bus.wdone = 1'b1;
        #1;
        chk("r0_spurious_wdone", req_wdone, 0);
        step();
        bus.wdone = 1'b0;
        chk("r0_state_kept_grant", grant, 2'b01);
        chk("r0_state_kept_cs",    bus.cs, 0);
        bus.rvalid = 1'b1;
        #1;
        chk("r0_rvalid", req_rvalid, 2'b01);
        step();
        bus.rvalid = 1'b0; req_cs = 2'b00;
        chk("r0_idle_grant", grant, 0);

        // Spurious rvalid in IDLE
        bus.rvalid = 1'b1;
        #1;
        chk("idle_spurious_rvalid", req_rvalid, 0);
        step();
        bus.rvalid = 1'b0;
        chk("idle_kept_grant", grant, 0);
        chk("idle_kept_cs",    bus.cs, 0);

        // Reset during WAIT_W
        req_cs = 2'b10; req_we = 2'b10;
        step();
        chk("rw_grant", grant, 2'b10);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; req_cs = 2'b11; req_we = 2'b00;
        bus.wdone = 1'b1;
        #1;
        chk("rw_grant0", grant, 0);
        chk("rw_cs0",    bus.cs, 0);
        chk("rw_we0",    bus.we, 0);
        chk("rw_addr0",  bus.addr, 0);
        chk("rw_wdata0", bus.wdata, 0);
        chk("rw_wdone0", req_wdone, 0);
        chk("rw_rvalid0", req_rvalid, 0);
        step();
        bus.wdone = 1'b0;
        chk("rw_first_grant", grant, 2'b01);
        chk("rw_first_cs",    bus.cs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
